// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, 8 lines x 4 words, read-only instruction cache.
// Hits are answered combinationally; a miss stalls the CPU while the
// 128-bit block is fetched from instruction memory and written into the line.
module instruction_cache #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [31:0]               PC,
    output logic [31:0]               INSTRUCTION,
    output logic                      BUSYWAIT,
    output logic                      MEM_READ,
    output logic [5:0]                MEM_ADDRESS,
    input  logic [32*BLOCK_WORDS-1:0] MEM_READDATA,
    input  logic                      MEM_BUSYWAIT
);

    localparam int BLOCK_BITS = 32 * BLOCK_WORDS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    state_t state, next_state;

    logic [BLOCK_BITS-1:0] data_array [NUM_BLOCKS];
    logic [2:0]            tag_array  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid;

    logic [5:0]            miss_addr;
    logic [BLOCK_BITS-1:0] fill_buf;

    logic [2:0] pc_tag;
    logic [2:0] pc_index;
    logic [1:0] pc_offset;
    logic       hit;
    logic       unused_pc_bits;

    // Address fields of the live fetch address; the outer bits play no part
    assign pc_tag         = PC[9:7];
    assign pc_index       = PC[6:4];
    assign pc_offset      = PC[3:2];
    assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

    // Hit check and word select against the line picked by the live PC
    always_comb begin
        hit         = valid[pc_index] && (tag_array[pc_index] == pc_tag);
        INSTRUCTION = 32'h0;
        if (RESET && hit) begin
            INSTRUCTION = data_array[pc_index][{pc_offset, 5'b00000} +: 32];
        end
    end

    // The miss-address register doubles as the memory address, so it holds between fills
    assign MEM_ADDRESS = miss_addr;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; stall is suppressed while reset is held
    always_comb begin
        next_state = state;
        BUSYWAIT   = 1'b0;
        MEM_READ   = 1'b0;
        case (state)
            S_IDLE: begin
                BUSYWAIT = !hit;
                if (!hit) begin
                    next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                BUSYWAIT   = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (!RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    // Miss address is captured once on the miss so later PC changes cannot disturb the fill
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            miss_addr <= 6'h00;
        end else if (state == S_IDLE && !hit) begin
            miss_addr <= {pc_tag, pc_index};
        end
    end

    // Fill buffer captures the block on the edge memory reports it ready
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fill_buf <= '0;
        end else if (state == S_MEM_READ && !MEM_BUSYWAIT) begin
            fill_buf <= MEM_READDATA;
        end
    end

    // Valid bits are the only array state that must be cleared on reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (state == S_UPDATE) begin
            valid[miss_addr[2:0]] <= 1'b1;
        end
    end

    // Data and tag arrays are only meaningful behind a valid bit, so they carry no reset
    always_ff @(posedge CLK) begin
        if (state == S_UPDATE) begin
            data_array[miss_addr[2:0]] <= fill_buf;
            tag_array[miss_addr[2:0]]  <= miss_addr[5:3];
        end
    end

endmodule
